// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding and default width for the calc host sequencer
package calc_pkg;

    localparam int CALC_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } calc_state_e;

endpackage

// File: rtl/calc_op_fifo.sv
// rtl/calc_op_fifo.sv - synchronous operand FIFO feeding the calc engine issue stage
module calc_op_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_en   = rd & !empty;
    // A pop in the same cycle frees the head slot, so a write while full is still accepted.
    assign wr_en   = wr & (!full | rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_host_seq.sv
// rtl/calc_host_seq.sv - issues buffered operands to the calc engine and holds its result for a reader
module calc_host_seq
    import calc_pkg::*;
#(
    parameter int W       = CALC_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         x_wr,
    input  logic [W-1:0] x_in,
    output logic         x_full,
    output logic         eng_in_valid,
    output logic [W-1:0] eng_x,
    input  logic         eng_out_valid,
    input  logic [W-1:0] eng_res,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    input  logic         res_ready,
    output logic         busy,
    output logic         timeout_err
);

    localparam int            TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    calc_state_e   state;
    calc_state_e   state_nxt;
    logic [TW-1:0] timer;
    logic          pop;
    logic          res_set;
    logic          timed_out;
    logic          fifo_empty;
    logic [W-1:0]  fifo_head;

    calc_op_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr      (x_wr),
        .wr_data (x_in),
        .rd      (pop),
        .rd_data (fifo_head),
        .full    (x_full),
        .empty   (fifo_empty)
    );

    assign eng_in_valid = (state == ISSUE);
    assign busy         = (state == ISSUE) || (state == WAIT);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        res_set   = 1'b0;
        timed_out = 1'b0;
        case (state)
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (eng_out_valid) begin
                    res_set   = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TIMER_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                // The engine cannot be stalled, so only issue once the result slot is free.
                if (!fifo_empty && !res_valid) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            eng_x       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                timer <= '0;
                eng_x <= fifo_head;
            end else if (busy) begin
                timer <= timer + TW'(1);
            end
            if (res_set) begin
                res_valid <= 1'b1;
                res_data  <= eng_res;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_host_seq.sv
// tb/tb_calc_host_seq.sv - directed bench for calc_host_seq with a small delayed-response engine model
module tb_calc_host_seq;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic         clock;
    logic         reset;
    logic         x_wr;
    logic [W-1:0] x_in;
    logic         x_full;
    logic         eng_in_valid;
    logic [W-1:0] eng_x;
    logic         eng_out_valid;
    logic [W-1:0] eng_res;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_ready;
    logic         busy;
    logic         timeout_err;

    int           n_pass = 0;
    int           n_total = 0;
    int           ivalid_pulses = 0;
    int           eng_delay = 0;
    int           eng_cnt = 0;
    logic [W-1:0] eng_pending = '0;
    logic         force_ov = 1'b0;
    logic [W-1:0] force_res = '0;

    typedef struct {
        logic [W-1:0] x;
        int           delay;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [5];

    calc_host_seq #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .x_wr          (x_wr),
        .x_in          (x_in),
        .x_full        (x_full),
        .eng_in_valid  (eng_in_valid),
        .eng_x         (eng_x),
        .eng_out_valid (eng_out_valid),
        .eng_res       (eng_res),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Engine: answers eng_x + 4 exactly eng_delay cycles after sampling input_valid.
    initial begin
        eng_out_valid = 1'b0;
        eng_res       = '0;
        forever begin
            @(posedge clock);
            #2;
            eng_out_valid = force_ov;
            eng_res       = force_res;
            if (!reset) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_out_valid = 1'b1;
                        eng_res       = eng_pending + 8'd4;
                    end
                end
                if (eng_in_valid && eng_delay > 0) begin
                    eng_pending = eng_x;
                    eng_cnt     = eng_delay;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (eng_in_valid) ivalid_pulses++;
    endtask

    task automatic wait_res(input string nm, input logic [W-1:0] exp);
        int i = 0;
        while (res_valid !== 1'b1 && i < 200) begin
            tick();
            i++;
        end
        chk({nm, "_seen"}, res_valid, 1);
        chk({nm, "_data"}, res_data, exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int bad = 0;
        eng_delay = v.delay;
        x_wr = 1'b1;
        x_in = v.x;
        tick();
        x_wr = 1'b0;
        chk($sformatf("v%0d_no_early_issue", idx), eng_in_valid, 0);
        tick();
        chk($sformatf("v%0d_issue", idx), eng_in_valid, 1);
        chk($sformatf("v%0d_eng_x", idx), eng_x, v.x);
        for (int j = 1; j <= v.delay; j++) begin
            tick();
            if (eng_in_valid !== 1'b0 || eng_x !== v.x || res_valid !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk($sformatf("v%0d_hold_cycles_bad", idx), bad, 0);
        tick();
        chk($sformatf("v%0d_res_valid", idx), res_valid, 1);
        chk($sformatf("v%0d_res_data", idx), res_data, v.exp);
        chk($sformatf("v%0d_idle", idx), busy, 0);
        chk($sformatf("v%0d_no_timeout", idx), timeout_err, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk($sformatf("v%0d_res_cleared", idx), res_valid, 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{x: 8'h05, delay: 6,           exp: 8'h09};
        vecs[1] = '{x: 8'h00, delay: 1,           exp: 8'h04};
        vecs[2] = '{x: 8'hA5, delay: 3,           exp: 8'hA9};
        vecs[3] = '{x: 8'hFE, delay: 2,           exp: 8'h02};
        vecs[4] = '{x: 8'h3C, delay: TIMEOUT - 1, exp: 8'h40};

        reset     = 1'b0;
        x_wr      = 1'b0;
        x_in      = '0;
        res_ready = 1'b0;
        #3;
        chk("rst_eng_in_valid", eng_in_valid, 0);
        chk("rst_eng_x", eng_x, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_x_full", x_full, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Back-pressure: only one operand in flight while the result is unread.
        eng_delay     = 2;
        ivalid_pulses = 0;
        x_wr = 1'b1; x_in = 8'h11; tick();
        x_in = 8'h22; tick();
        x_in = 8'h33; tick();
        x_wr = 1'b0;
        repeat (20) tick();
        chk("bp_single_issue", ivalid_pulses, 1);
        chk("bp_res_held", res_valid, 1);
        chk("bp_first_data", res_data, 8'h15);
        wait_res("bp_a", 8'h15);
        repeat (20) tick();
        chk("bp_second_issue", ivalid_pulses, 2);
        wait_res("bp_b", 8'h26);
        repeat (20) tick();
        chk("bp_third_issue", ivalid_pulses, 3);
        chk("bp_third_held", res_valid, 1);

        // FIFO full while the held result blocks issue.
        for (int i = 0; i < 3; i++) begin
            x_wr = 1'b1;
            x_in = 8'h40 + 8'(i);
            tick();
        end
        x_wr = 1'b0;
        chk("fifo_not_full_3", x_full, 0);
        x_wr = 1'b1; x_in = 8'h43; tick();
        x_wr = 1'b0;
        chk("fifo_full_4", x_full, 1);
        x_wr = 1'b1; x_in = 8'h44; tick();
        x_wr = 1'b0;
        chk("fifo_full_after_drop", x_full, 1);
        wait_res("bp_c", 8'h37);
        chk("fifo_full_before_pop", x_full, 1);
        x_wr = 1'b1; x_in = 8'h45; tick();
        x_wr = 1'b0;
        chk("fifo_popwrite_keeps_full", x_full, 1);
        wait_res("fifo_0", 8'h44);
        wait_res("fifo_1", 8'h45);
        wait_res("fifo_2", 8'h46);
        wait_res("fifo_3", 8'h47);
        wait_res("fifo_4", 8'h49);
        repeat (10) tick();
        chk("fifo_drained", res_valid, 0);
        chk("fifo_not_full_end", x_full, 0);

        // Timeout: engine never answers the first operand.
        eng_delay = -1;
        x_wr = 1'b1; x_in = 8'h77; tick();
        x_wr = 1'b0;
        tick();
        chk("to_issue", eng_in_valid, 1);
        bad = 0;
        for (int j = 1; j < TIMEOUT; j++) begin
            tick();
            if (j == 1) begin
                eng_delay = 2;
                x_wr      = 1'b1;
                x_in      = 8'h78;
            end else begin
                x_wr = 1'b0;
            end
            if (timeout_err !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("to_early_cycles_bad", bad, 0);
        tick();
        chk("to_err_set", timeout_err, 1);
        chk("to_idle", busy, 0);
        chk("to_no_result", res_valid, 0);
        tick();
        chk("to_next_issue", eng_in_valid, 1);
        chk("to_next_eng_x", eng_x, 8'h78);
        wait_res("to_next", 8'h7C);
        chk("to_err_sticky", timeout_err, 1);

        // Spurious engine output while idle.
        force_res = 8'hAA;
        force_ov  = 1'b1;
        tick(); tick(); tick();
        force_ov = 1'b0;
        tick();
        chk("spur_res_valid", res_valid, 0);
        chk("spur_res_data", res_data, 8'h7C);

        // Asynchronous reset in the middle of WAIT.
        eng_delay = 10;
        x_wr = 1'b1; x_in = 8'h99; tick();
        x_in = 8'h9A; tick();
        x_wr = 1'b0;
        tick(); tick();
        chk("rw_in_wait", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_eng_in_valid", eng_in_valid, 0);
        chk("rw_eng_x", eng_x, 0);
        chk("rw_res_valid", res_valid, 0);
        chk("rw_res_data", res_data, 0);
        chk("rw_timeout_err", timeout_err, 0);
        chk("rw_x_full", x_full, 0);
        @(posedge clock);
        #1;
        reset         = 1'b1;
        ivalid_pulses = 0;
        repeat (12) tick();
        chk("rw_fifo_empty_no_issue", ivalid_pulses, 0);
        chk("rw_idle_after", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
